serial_rx: RTL and testbench

SERIAL_RX -- requirements
Module: serial_rx

---
 rtl/serial_rx.sv | 145 ++++++++++++++
 tb/tb_serial_rx.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_rx.sv
// Strobed serial receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Optional parity stage enabled by defining SERIAL_RX_PARITY_EN.
module serial_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              d,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              frame_err,
    output logic              overrun,
    output logic              parity_err
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
`ifdef SERIAL_RX_PARITY_EN
        PARITY = 2'd3,
`endif
        STOP   = 2'd2
    } state_t;

    state_t            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] data_r;
    logic              valid_r;
    logic              frame_err_r;
    logic              overrun_r;
    logic              par_ok_s;

`ifdef SERIAL_RX_PARITY_EN
    logic              par_bit_r;
    logic              parity_err_r;

    function automatic logic even_parity(input logic [DATA_W-1:0] v);
        return ^v;
    endfunction

    // Received parity bit must make the total count of ones even
    always_comb begin
        par_ok_s = 1'b1;
        if (even_parity(shift_r) != par_bit_r) begin
            par_ok_s = 1'b0;
        end else begin
            par_ok_s = 1'b1;
        end
    end

    assign parity_err = parity_err_r;
`else
    // Without a parity stage every frame passes the parity check
    always_comb begin
        par_ok_s = 1'b1;
    end

    assign parity_err = 1'b0;
`endif

    // Frame FSM, holding register with handshake, and single-cycle error pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            shift_r     <= {DATA_W{1'b0}};
            data_r      <= {DATA_W{1'b0}};
            valid_r     <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            par_bit_r    <= 1'b0;
            parity_err_r <= 1'b0;
`endif
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
            parity_err_r <= 1'b0;
`endif
            if (valid_r && ready) begin
                valid_r <= 1'b0;
            end
            if (en) begin
                case (state_r)
                    IDLE: begin
                        if (!d) begin
                            state_r <= DATA;
                            cnt_r   <= {CNT_W{1'b0}};
                        end
                    end
                    DATA: begin
                        shift_r[cnt_r] <= d;
                        if (cnt_r == CNT_W'(DATA_W - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                            state_r <= PARITY;
`else
                            state_r <= STOP;
`endif
                        end else begin
                            cnt_r <= cnt_r + CNT_W'(1);
                        end
                    end
`ifdef SERIAL_RX_PARITY_EN
                    PARITY: begin
                        par_bit_r <= d;
                        state_r   <= STOP;
                    end
`endif
                    STOP: begin
                        state_r <= IDLE;
                        if (d && par_ok_s) begin
                            // A full, unconsumed holding register drops the new word
                            if (valid_r && !ready) begin
                                overrun_r <= 1'b1;
                            end else begin
                                data_r  <= shift_r;
                                valid_r <= 1'b1;
                            end
                        end else begin
                            frame_err_r <= ~d;
`ifdef SERIAL_RX_PARITY_EN
                            parity_err_r <= ~par_ok_s;
`endif
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_r;
    assign valid     = valid_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_serial_rx.sv
// Scoreboard bench for serial_rx: each frame pushes its expected outcome, popped at the stop-bit edge.
module tb_serial_rx;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       d;
    logic       ready;
    logic [7:0] data_out;
    logic       valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int checks_cnt = 0;
    int errors_cnt = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       vld;
        logic       ferr;
        logic       perr;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];

    logic [7:0] m_data;
    logic       m_valid;

    serial_rx #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .d         (d),
        .ready     (ready),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .overrun   (overrun),
        .parity_err(parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks_cnt++;
        if (obs !== exp_v) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One bit cell: stride-1 non-strobe cycles carry the inverted level as glitches
    task automatic send_bit(input logic b, input int stride, input logic rdy);
        for (int k = 0; k < stride; k++) begin
            en    = (k == stride - 1);
            d     = en ? b : ~b;
            ready = en ? rdy : 1'b0;
            tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] dat, input logic stop_b, input logic par_flip,
                              input int stride, input logic rdy_stop);
        exp_t e;
        logic par_ok;
        exp_t got;
`ifdef SERIAL_RX_PARITY_EN
        par_ok = ~par_flip;
`else
        par_ok = 1'b1;
`endif
        e = '0;
        e.ferr = ~stop_b;
        e.perr = stop_b ? ~par_ok : ~par_ok;
        if (stop_b && par_ok) begin
            if (m_valid && !rdy_stop) begin
                e.ovr = 1'b1;
            end else begin
                m_data  = dat;
                m_valid = 1'b1;
            end
        end else if (m_valid && rdy_stop) begin
            m_valid = 1'b0;
        end
        e.data = m_data;
        e.vld  = m_valid;
        exp_q.push_back(e);

        send_bit(1'b0, stride, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(dat[i], stride, 1'b0);
`ifdef SERIAL_RX_PARITY_EN
        send_bit((^dat) ^ par_flip, stride, 1'b0);
`endif
        send_bit(stop_b, stride, rdy_stop);

        got = exp_q.pop_front();
        check_val("data_out", {24'd0, data_out}, {24'd0, got.data});
        check_val("valid", {31'd0, valid}, {31'd0, got.vld});
        check_val("frame_err", {31'd0, frame_err}, {31'd0, got.ferr});
        check_val("parity_err", {31'd0, parity_err}, {31'd0, got.perr});
        check_val("overrun", {31'd0, overrun}, {31'd0, got.ovr});

        // Idle strobe afterwards: every pulse must already be gone
        en = 1'b1; d = 1'b1; ready = 1'b0;
        tick();
        check_val("pulse_ferr", {31'd0, frame_err}, 32'd0);
        check_val("pulse_perr", {31'd0, parity_err}, 32'd0);
        check_val("pulse_ovr", {31'd0, overrun}, 32'd0);
        en = 1'b0;
    endtask

    task automatic consume();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        m_valid = 1'b0;
        check_val("consume_valid", {31'd0, valid}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; d = 1'b1; ready = 1'b0;
        m_data = 8'h00; m_valid = 1'b0;
        #12;
        check_val("rst_data", {24'd0, data_out}, 32'd0);
        check_val("rst_valid", {31'd0, valid}, 32'd0);
        check_val("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_val("rst_ovr", {31'd0, overrun}, 32'd0);
        check_val("rst_perr", {31'd0, parity_err}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Bad stop bit straight after reset: data_out remains zero
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0);

        send_frame(8'hA5, 1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_data", {24'd0, data_out}, 32'h0000_00A5);
        end
        consume();
        send_frame(8'hA5, 1'b1, 1'b0, 3, 1'b0);
        consume();

        send_frame(8'h11, 1'b1, 1'b0, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1, 1'b0);
        consume();
        send_frame(8'h11, 1'b1, 1'b0, 2, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 2, 1'b1);
        consume();

`ifdef SERIAL_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0, 1, 1'b0);
        consume();
        send_frame(8'h07, 1'b0, 1'b1, 1, 1'b0);
`endif

        for (int n = 0; n < 12; n++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 4) != 0),
                       ($urandom_range(0, 3) == 0), $urandom_range(1, 3),
                       1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) consume();
        end

        // Async reset in the middle of a frame with a word still held
        send_frame(8'h33, 1'b1, 1'b0, 1, 1'b0);
        send_bit(1'b0, 1, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_data", {24'd0, data_out}, 32'd0);
        check_val("async_valid", {31'd0, valid}, 32'd0);
        m_data = 8'h00; m_valid = 1'b0;
        en = 1'b1; d = 1'b1;
        tick();
        rst_n = 1'b1;
        en = 1'b0;
        tick();
        send_frame(8'h5A, 1'b1, 1'b0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
